// File: rtl/booth_multiplier32.sv
// booth_multiplier32 - iterative 32x32 -> 64-bit multiplier, one radix-2 Booth
// step per clock, using a 32-bit adder/subtractor for the accumulator update.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         request, sampled only while idle
//   multiplicand  operand M, captured on the accepted start
//   multiplier    operand Q, captured on the accepted start
//   is_signed     signed/unsigned select (only with MUL_UNSIGNED_EN)
//   busy          high while an operation is running or completing
//   done          one-cycle completion pulse
//   product       64-bit result, held until the next completion or reset
//   overflow      product does not fit in 32 bits (signed or unsigned sense)
//
// Optional feature macro: MUL_UNSIGNED_EN adds the is_signed port and an
// unsigned shift-add mode. Without it the unit is always signed Booth.
module booth_multiplier32 #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
`ifdef MUL_UNSIGNED_EN
  input  logic        is_signed,
`endif
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] m_q, a_q, q_q;
  logic        q1_q;
  logic [5:0]  cnt_q;
  logic        signed_mode;

`ifdef MUL_UNSIGNED_EN
  logic        sgn_q;
  assign signed_mode = sgn_q;
`else
  assign signed_mode = 1'b1;
`endif

  // Adder/subtractor datapath: a=A, b=M
  logic [31:0] add_a, add_b, bx, sum;
  logic        subtract, carryout, add_ovf;

  assign bx = subtract ? ~add_b : add_b;
  assign {carryout, sum} = {1'b0, add_a} + {1'b0, bx} + {32'b0, subtract};
  // Signed overflow = carry into MSB xor carry out of MSB.
  assign add_ovf = carryout ^ sum[31] ^ add_a[31] ^ bx[31];

  // One iteration: decode, optional add/sub, then shift right by one.
  logic        do_add, msb;
  logic [31:0] new_a, a_nxt, q_nxt;
  logic [63:0] prod_nxt;

  always_comb begin
    add_a    = a_q;
    add_b    = m_q;
    subtract = 1'b0;
    do_add   = 1'b0;
    if (signed_mode) begin
      case ({q_q[0], q1_q})
        2'b01:   do_add = 1'b1;
        2'b10:   begin do_add = 1'b1; subtract = 1'b1; end
        default: do_add = 1'b0;
      endcase
    end else begin
      do_add = q_q[0];
    end
    new_a = do_add ? sum : a_q;
    // Shifted-in MSB: true sign of A (signed) or adder carry (unsigned).
    if (signed_mode)
      msb = do_add ? (sum[31] ^ add_ovf) : a_q[31];
    else
      msb = do_add ? carryout : 1'b0;
    a_nxt    = {msb, new_a[31:1]};
    q_nxt    = {new_a[0], q_q[31:1]};
    prod_nxt = {a_nxt, q_nxt};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt_q == 6'(ITER - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      m_q      <= '0;
      a_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      cnt_q    <= '0;
      product  <= '0;
      overflow <= 1'b0;
`ifdef MUL_UNSIGNED_EN
      sgn_q    <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          a_q   <= '0;
          q_q   <= multiplier;
          m_q   <= multiplicand;
          q1_q  <= 1'b0;
          cnt_q <= '0;
`ifdef MUL_UNSIGNED_EN
          sgn_q <= is_signed;
`endif
        end
        RUN: begin
          a_q   <= a_nxt;
          q_q   <= q_nxt;
          q1_q  <= q_q[0];
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(ITER - 1)) begin
            product  <= prod_nxt;
            overflow <= signed_mode ? (prod_nxt[63:32] != {32{prod_nxt[31]}})
                                    : (prod_nxt[63:32] != 32'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier32.sv
module tb_booth_multiplier32;

  logic        clk = 1'b0;
  logic        reset, start, is_sg;
  logic [31:0] multiplicand, multiplier;
  logic        busy, done, overflow;
  logic [63:0] product;

`ifdef MUL_UNSIGNED_EN
  localparam bit UNS = 1'b1;
`else
  localparam bit UNS = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  booth_multiplier32 dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
`ifdef MUL_UNSIGNED_EN
    .is_signed(is_sg),
`endif
    .busy(busy), .done(done), .product(product), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q, input bit s);
    longint a, b;
    if (s) begin a = longint'($signed(m)); b = longint'($signed(q)); end
    else   begin a = longint'({32'b0, m}); b = longint'({32'b0, q}); end
    return 64'(a * b);
  endfunction

  function automatic bit ref_ovf(input logic [63:0] p, input bit s);
    return s ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'd0);
  endfunction

  // Behavioural model: tracks cycles since the accepted start; the result
  // is plain multiplication, published when the operation completes.
  bit          mb, md, mo;
  logic [63:0] mp, mpend;
  bit          mopend;
  int          mcnt;

  always @(posedge clk) begin
    if (reset) begin
      mb <= 0; md <= 0; mp <= '0; mo <= 0; mcnt <= 0;
    end else if (md) begin
      md <= 0; mb <= 0;
    end else if (mb) begin
      if (mcnt == 32) begin md <= 1; mp <= mpend; mo <= mopend; end
      else mcnt <= mcnt + 1;
    end else if (start) begin
      mb     <= 1;
      mcnt   <= 1;
      mpend  <= ref_prod(multiplicand, multiplier, UNS ? is_sg : 1'b1);
      mopend <= ref_ovf(ref_prod(multiplicand, multiplier, UNS ? is_sg : 1'b1), UNS ? is_sg : 1'b1);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(busy), 64'(mb));
      chk("cyc_done", 64'(done), 64'(md));
      chk("cyc_product", product, mp);
      chk("cyc_overflow", 64'(overflow), 64'(mo));
    end
  end

  // Issue one operation; edges counts clock edges from the start edge
  // through the edge after which done is seen.
  task automatic mul(input logic [31:0] m, input logic [31:0] q, input bit s, output int edges);
    @(negedge clk);
    multiplicand = m; multiplier = q; is_sg = s; start = 1'b1;
    @(posedge clk);
    edges = 1;
    #2 start = 1'b0;
    while (!done && edges < 60) begin
      @(posedge clk); edges++; #1;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done expected done within 60 edges");
    end
    @(negedge clk);
  endtask

  int e, npulse;
  logic [31:0] specials [6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'hFFFF_FFFE};

  initial begin
    reset = 1'b1; start = 1'b0; is_sg = 1'b1;
    multiplicand = '0; multiplier = '0;
    // 1: reset for two cycles, then idle for five
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_idle", {busy, done, overflow, product[60:0]}, 64'd0);
    end

    // 2: signed small product and latency
    mul(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, e);
    chk("t2_edges", 64'(e), 64'd33);
    chk("t2_prod", product, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("t2_ovf", 64'(overflow), 64'd0);
    chk("t2_model", mp, 64'hFFFF_FFFF_FFFF_FFF1);

    // 3: boundary operands
    mul(32'h8000_0000, 32'h8000_0000, 1'b1, e);
    chk("t3a_prod", product, 64'h4000_0000_0000_0000);
    chk("t3a_ovf", 64'(overflow), 64'd1);
    mul(32'h7FFF_FFFF, 32'h0000_0002, 1'b1, e);
    chk("t3b_prod", product, 64'h0000_0000_FFFF_FFFE);
    chk("t3b_ovf", 64'(overflow), 64'd1);
    chk("t3b_model", mp, 64'h0000_0000_FFFF_FFFE);

`ifdef MUL_UNSIGNED_EN
    // 4: signed vs unsigned interpretation of all-ones
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, e);
    chk("t4s_prod", product, 64'h0000_0000_0000_0001);
    chk("t4s_ovf", 64'(overflow), 64'd0);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, e);
    chk("t4u_prod", product, 64'hFFFF_FFFE_0000_0001);
    chk("t4u_ovf", 64'(overflow), 64'd1);
`endif

    // 5: start re-pulsed while busy is ignored
    @(negedge clk);
    multiplicand = 32'hFFFF_FFFD; multiplier = 32'h5; is_sg = 1'b1; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    multiplicand = 32'h1234_5678; multiplier = 32'h9ABC_DEF0; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("t5_pulses", 64'(npulse), 64'd1);
    chk("t5_prod", product, 64'hFFFF_FFFF_FFFF_FFF1);

    // 6: reset mid-run abandons the operation
    @(negedge clk);
    multiplicand = 32'h0000_0007; multiplier = 32'h0000_0009; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_prod", product, 64'd0);
    mul(32'h0000_0007, 32'h0000_0009, 1'b1, e);
    chk("t6_prod_after", product, 64'd63);

    // Random operations, with occasional boundary operands
    for (int k = 0; k < 40; k++) begin
      logic [31:0] m, q;
      bit s;
      m = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      q = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      s = UNS ? 1'($urandom_range(0, 1)) : 1'b1;
      mul(m, q, s, e);
      chk("rnd_edges", 64'(e), 64'd33);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
